// File: rtl/kinase_valve_sequencer_if.sv
// ============================================================================
//  Module      : kinase_valve_sequencer_if
//  Description : Host command channel for kinase_valve_sequencer.
//                A valid/ready handshake carries a 2-bit opcode and an operand.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface kinase_valve_sequencer_if #(
   parameter int ARG_W = 16
) ();
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [ARG_W-1:0] cmd_arg;

   // Host side: offers commands.
   modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
   // Sequencer side: accepts commands.
   modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

`default_nettype wire

// File: rtl/kinase_valve_sequencer.sv
// ============================================================================
//  Module      : kinase_valve_sequencer
//  Description : Turns host commands into valve/pump control pins for the
//                kinase_activity chip: static valve writes, peristaltic pump
//                stroke sequences and timed waits.
//                Optional feature macro: KVS_ABORT_EN (adds the abort input).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module kinase_valve_sequencer #(
   parameter int PHASE_CYCLES = 1000,
   parameter int ARG_W        = 16
) (
   input  wire                     clk,
   input  wire                     rst_n,
   kinase_valve_sequencer_if.slave cmd,
   output logic [12:0]             ctrl_a,
   output logic [3:0]              ctrl_s,
   output logic [2:0]              pump_a,
   output logic [1:0]              pump_b,
   output logic                    busy,
   output logic                    done
`ifdef KVS_ABORT_EN
   ,
   input  wire                     abort
`endif
);

   localparam int TMR_W = $clog2(PHASE_CYCLES + 1);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_pump = 2'd1;
   localparam logic [1:0] c_wait = 2'd2;

   localparam logic [1:0] c_op_set_a = 2'd0;
   localparam logic [1:0] c_op_set_s = 2'd1;
   localparam logic [1:0] c_op_pump  = 2'd2;
   localparam logic [1:0] c_op_wait  = 2'd3;

   localparam logic [TMR_W-1:0] c_tmr_load = TMR_W'(PHASE_CYCLES - 1);

   // Pump A phase table (6 phases per stroke).
   function automatic logic [2:0] pat_a(input logic [2:0] idx);
      case (idx)
         3'd0:    pat_a = 3'b011;
         3'd1:    pat_a = 3'b001;
         3'd2:    pat_a = 3'b101;
         3'd3:    pat_a = 3'b100;
         3'd4:    pat_a = 3'b110;
         3'd5:    pat_a = 3'b010;
         default: pat_a = 3'b111;
      endcase
   endfunction

   // Pump B phase table (4 phases per stroke).
   function automatic logic [1:0] pat_b(input logic [2:0] idx);
      case (idx)
         3'd0:    pat_b = 2'b10;
         3'd1:    pat_b = 2'b00;
         3'd2:    pat_b = 2'b01;
         3'd3:    pat_b = 2'b11;
         default: pat_b = 2'b11;
      endcase
   endfunction

   logic [1:0]       r_state, w_state_nxt;
   logic             r_pump_b_sel, w_sel_nxt;
   logic [2:0]       r_phase_idx, w_idx_nxt;
   logic [TMR_W-1:0] r_phase_tmr;
   logic [11:0]      r_stroke_cnt;
   logic [ARG_W-1:0] r_wait_cnt;
   logic [12:0]      r_ctrl_a;
   logic [3:0]       r_ctrl_s;
   logic [2:0]       r_pump_a, w_pump_a_nxt;
   logic [1:0]       r_pump_b, w_pump_b_nxt;
   logic             r_done, w_done_nxt;

   logic w_accept, w_pump_go, w_wait_go, w_phase_end, w_last_phase;
   logic w_pump_fin, w_wait_fin, w_abort;

   assign w_accept     = cmd.cmd_valid && (r_state == c_idle);
   assign w_pump_go    = w_accept && (cmd.cmd_op == c_op_pump) && (cmd.cmd_arg[11:0] != 12'd0);
   assign w_wait_go    = w_accept && (cmd.cmd_op == c_op_wait) && (cmd.cmd_arg != '0);
   assign w_phase_end  = (r_state == c_pump) && (r_phase_tmr == '0);
   assign w_last_phase = r_pump_b_sel ? (r_phase_idx == 3'd3) : (r_phase_idx == 3'd5);
   assign w_pump_fin   = w_phase_end && w_last_phase && (r_stroke_cnt == 12'd1);
   assign w_wait_fin   = (r_state == c_wait) && (r_wait_cnt == '0);
`ifdef KVS_ABORT_EN
   assign w_abort      = abort && (r_state != c_idle);
`else
   assign w_abort      = 1'b0;
`endif

   // Pump selection and phase index as they will be after this edge.
   assign w_sel_nxt = w_pump_go ? cmd.cmd_arg[15] : r_pump_b_sel;
   assign w_idx_nxt = w_pump_go   ? 3'd0 :
                      w_phase_end ? (w_last_phase ? 3'd0 : r_phase_idx + 3'd1) :
                                    r_phase_idx;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= c_idle;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic; abort outranks normal completion.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_idle: begin
            if (w_pump_go)      w_state_nxt = c_pump;
            else if (w_wait_go) w_state_nxt = c_wait;
         end
         c_pump:  if (w_abort || w_pump_fin) w_state_nxt = c_idle;
         c_wait:  if (w_abort || w_wait_fin) w_state_nxt = c_idle;
         default: w_state_nxt = c_idle;
      endcase
   end

   // Output decode: handshake, busy, done and next pump patterns.
   always_comb begin
      cmd.cmd_ready = (r_state == c_idle);
      busy          = (r_state != c_idle);
      w_done_nxt    = (w_pump_fin || w_wait_fin) && !w_abort;
      w_pump_a_nxt  = 3'b111;
      w_pump_b_nxt  = 2'b11;
      if (w_state_nxt == c_pump) begin
         if (w_sel_nxt) w_pump_b_nxt = pat_b(w_idx_nxt);
         else           w_pump_a_nxt = pat_a(w_idx_nxt);
      end
   end

   // Datapath: valve registers, counters and registered pad outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ctrl_a     <= 13'h1FFF;
         r_ctrl_s     <= 4'hF;
         r_pump_a     <= 3'b111;
         r_pump_b     <= 2'b11;
         r_done       <= 1'b0;
         r_pump_b_sel <= 1'b0;
         r_phase_idx  <= 3'd0;
         r_phase_tmr  <= '0;
         r_stroke_cnt <= 12'd0;
         r_wait_cnt   <= '0;
      end else begin
         r_pump_a     <= w_pump_a_nxt;
         r_pump_b     <= w_pump_b_nxt;
         r_done       <= w_done_nxt;
         r_pump_b_sel <= w_sel_nxt;
         r_phase_idx  <= w_idx_nxt;

         if (w_accept && (cmd.cmd_op == c_op_set_a)) r_ctrl_a <= cmd.cmd_arg[12:0];
         if (w_accept && (cmd.cmd_op == c_op_set_s)) r_ctrl_s <= cmd.cmd_arg[3:0];

         if (w_pump_go || w_phase_end)  r_phase_tmr <= c_tmr_load;
         else if (r_state == c_pump)    r_phase_tmr <= r_phase_tmr - 1'b1;

         if (w_pump_go)
            r_stroke_cnt <= cmd.cmd_arg[11:0];
         else if (w_phase_end && w_last_phase && (r_stroke_cnt != 12'd0))
            r_stroke_cnt <= r_stroke_cnt - 12'd1;

         if (w_wait_go)
            r_wait_cnt <= cmd.cmd_arg - ARG_W'(1);
         else if ((r_state == c_wait) && (r_wait_cnt != '0))
            r_wait_cnt <= r_wait_cnt - ARG_W'(1);
      end
   end

   assign ctrl_a = r_ctrl_a;
   assign ctrl_s = r_ctrl_s;
   assign pump_a = r_pump_a;
   assign pump_b = r_pump_b;
   assign done   = r_done;

endmodule

`default_nettype wire
